// File: rtl/rv_branch_pkg.sv
// Shared branch definitions: BHT counter encodings, immediate width, funct3 codes.
package rv_branch_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned BIMM_W    = 13;
  localparam int unsigned BHT_CNT_W = 2;

  // 2-bit saturating direction counter; MSB is the taken prediction
  typedef enum logic [BHT_CNT_W-1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_cnt_e;

  localparam bht_cnt_e BHT_INIT = BHT_WNT;

  // Conditional-branch funct3 codes, shared with the comparator
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // PC-carrying single-cycle event (redirect or misalign report)
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } pc_event_t;

  // True for funct3 values that encode a conditional branch
  function automatic logic is_branch_f3(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  // Saturating counter step toward the resolved direction
  function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
    bht_cnt_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != BHT_ST) nxt = bht_cnt_e'(BHT_CNT_W'(cur) + BHT_CNT_W'(1));
    end else begin
      if (cur != BHT_SNT) nxt = bht_cnt_e'(BHT_CNT_W'(cur) - BHT_CNT_W'(1));
    end
    return nxt;
  endfunction

  // Sign-extend a B-type immediate to XLEN
  function automatic logic [XLEN-1:0] sext_bimm(input logic [BIMM_W-1:0] imm);
    return {{(XLEN-BIMM_W){imm[BIMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/bht_table.sv
// Direct-mapped table of 2-bit direction counters: one comb read, one sync update.
module bht_table
  import rv_branch_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [BHT_CNT_W-1:0] tbl [DEPTH];

  // Reset every entry to weakly not-taken; otherwise step the addressed counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl[i] <= BHT_INIT;
      end
    end else if (upd_en) begin
      tbl[upd_idx] <= bht_next(bht_cnt_e'(tbl[upd_idx]), upd_taken);
    end
  end

  // Read reflects table state only; a same-cycle update is not forwarded
  assign rd_taken = tbl[rd_idx][BHT_CNT_W-1];

endmodule

// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolution: redirect/misalign reporting, BHT training, perf counters.
module branch_resolve_bht
  import rv_branch_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_stall,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [BIMM_W-1:0] ex_imm,
  input  logic              ex_brE,
  input  logic              ex_pred_taken,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              misalign_exc,
  output logic [XLEN-1:0]   misalign_addr,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mispred_count
);

  pc_event_t        redir_q;
  pc_event_t        misal_q;
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] mp_q;

  logic [XLEN-1:0]  target_c;
  logic [XLEN-1:0]  fallthrough_c;
  logic             resolve_c;
  logic             misalign_c;
  logic             mispred_c;
  logic             unused_pc_bits;

  // Saturating +1 for perf counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Target and fallthrough wrap modulo 2**XLEN
  assign target_c      = ex_pc + sext_bimm(ex_imm);
  assign fallthrough_c = ex_pc + XLEN'(4);

  // The slot right behind a redirect is wrong-path and must not resolve
  assign resolve_c  = ex_valid & ex_is_branch & ~ex_stall & ~redir_q.valid;
  assign misalign_c = ex_brE & (target_c[1:0] != 2'b00);
  assign mispred_c  = ~misalign_c & (ex_brE != ex_pred_taken);

  bht_table #(
    .IDX_W (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_taken  (if_pred_taken),
    .upd_en    (resolve_c & ~misalign_c),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (ex_brE)
  );

  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  // Resolution registers: pulses clear every cycle, addresses and counters hold
  always_ff @(posedge clk) begin
    if (rst) begin
      redir_q <= '0;
      misal_q <= '0;
      br_q    <= '0;
      mp_q    <= '0;
    end else begin
      redir_q.valid <= 1'b0;
      misal_q.valid <= 1'b0;
      if (resolve_c) begin
        br_q <= sat_inc(br_q);
        if (misalign_c) begin
          misal_q.valid <= 1'b1;
          misal_q.pc    <= target_c;
        end else if (mispred_c) begin
          redir_q.valid <= 1'b1;
          redir_q.pc    <= ex_brE ? target_c : fallthrough_c;
          mp_q          <= sat_inc(mp_q);
        end
      end
    end
  end

  assign redirect_valid = redir_q.valid;
  assign redirect_pc    = redir_q.pc;
  assign misalign_exc   = misal_q.valid;
  assign misalign_addr  = misal_q.pc;
  assign br_count       = br_q;
  assign mispred_count  = mp_q;

endmodule
